// File: rtl/delay_pkg.sv
// Shared types and helpers for the fixed-latency delay line and its flow controller.
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } flow_state_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/delay.sv
// Fixed-latency data delay line: CYCLES register stages advancing together on en.
module delay #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [CYCLES];

  genvar gi;
  generate
    for (gi = 0; gi < CYCLES; gi++) begin : g_stage
      logic [WIDTH-1:0] data_reg;
      logic [WIDTH-1:0] data_next;

      if (gi == 0) begin : g_first
        assign data_next = d;
      end else begin : g_rest
        assign data_next = stage_q[gi-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (en) begin
          data_reg <= data_next;
        end
      end

      assign stage_q[gi] = data_reg;
    end
  endgenerate

  assign q = stage_q[CYCLES-1];

endmodule

// File: rtl/delay_flow_ctrl.sv
// Valid/ready wrapper around a fixed-latency delay line: per-stage valid bits,
// global stall, occupancy count, and flush/drain sequencing.
module delay_flow_ctrl
  import delay_pkg::*;
#(
  parameter  int CYCLES = 4,
  parameter  int WIDTH  = 8,
  localparam int CW     = cnt_width(CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [CW-1:0]    count,
  output logic             busy
);

  flow_state_t      state_reg, state_next;
  logic [CYCLES:1]  v_reg, v_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             drain_done_reg, drain_done_next;
  logic             en;
  logic             accept;
  logic             deliver;

  // Whole pipe stalls only when the last stage is full and the consumer refuses it.
  assign en      = !v_reg[CYCLES] || out_ready;
  assign accept  = in_valid && in_ready;
  assign deliver = v_reg[CYCLES] && out_ready;

  delay #(
    .WIDTH (WIDTH),
    .CYCLES(CYCLES)
  ) u_delay (
    .clk(clk),
    .rst(1'b0),
    .en (en),
    .d  (in_data),
    .q  (out_data)
  );

  always_comb begin
    v_next     = v_reg;
    count_next = count_reg + CW'(accept) - CW'(deliver);
    if (en) begin
      v_next[1] = accept;
      for (int i = 2; i <= CYCLES; i++) begin
        v_next[i] = v_reg[i-1];
      end
    end
    if (flush) begin
      v_next     = '0;
      count_next = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      v_reg          <= '0;
      count_reg      <= '0;
      drain_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      v_reg          <= v_next;
      count_reg      <= count_next;
      drain_done_reg <= drain_done_next;
    end
  end

  // Next-state logic; flush overrides everything and aborts a drain silently.
  always_comb begin
    state_next      = state_reg;
    drain_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (drain_req)   state_next = DRAIN;
        else if (accept) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (drain_req)             state_next = DRAIN;
        else if (count_next == '0) state_next = IDLE;
      end
      DRAIN: begin
        if (count_reg == '0) begin
          state_next      = IDLE;
          drain_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next      = IDLE;
      drain_done_next = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    in_ready = en && (state_reg != DRAIN) && !flush && !rst;
    busy     = (state_reg != IDLE) || (count_reg != '0);
  end

  assign out_valid  = v_reg[CYCLES];
  assign count      = count_reg;
  assign drain_done = drain_done_reg;

endmodule
